// File: rtl/pixel_fade_ctrl.sv
// rtl/pixel_fade_ctrl.sv - brightness fade sequencer around a saturating 4-bit RGB shader
// Optional fade_done pulse output: define PIXEL_FADE_DONE_PULSE_EN.

module pixel_shader_4bit (
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  input  logic [3:0] bright,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out
);

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  assign red_out   = sat_add(red_in, bright);
  assign green_out = sat_add(green_in, bright);
  assign blue_out  = sat_add(blue_in, bright);

endmodule

module pixel_fade_ctrl #(
  parameter int STEP_W     = 8,
  parameter int MAX_BRIGHT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [3:0]        red_in,
  input  logic [3:0]        green_in,
  input  logic [3:0]        blue_in,
  input  logic              pix_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        red_out,
  output logic [3:0]        green_out,
  output logic [3:0]        blue_out,
  output logic              out_last,
  input  logic              fade_start,
  input  logic [3:0]        fade_target,
  input  logic [STEP_W-1:0] fade_step_frames,
  input  logic              bright_set,
  input  logic [3:0]        bright_val,
  output logic [3:0]        bright_level,
  output logic              fade_busy
`ifdef PIXEL_FADE_DONE_PULSE_EN
  ,
  output logic              fade_done
`endif
);

  localparam logic [3:0] MAX_L = 4'(MAX_BRIGHT);

  typedef enum logic [1:0] {IDLE, FADE_UP, FADE_DOWN} state_t;

  state_t              state;
  logic [3:0]          target;
  logic [STEP_W-1:0]   period;
  logic [STEP_W-1:0]   frame_cnt;
  logic                accept;
  logic [3:0]          shade_r, shade_g, shade_b;
  logic [3:0]          start_tgt;
  logic [STEP_W-1:0]   start_per;
  logic [3:0]          next_lvl;
  logic                step_now;
  logic                done_set;

  function automatic logic [3:0] clamp(input logic [3:0] v);
    return (v > MAX_L) ? MAX_L : v;
  endfunction

  assign pix_ready = !out_valid || out_ready;
  assign accept    = pix_valid && pix_ready;
  assign start_tgt = clamp(fade_target);
  assign start_per = (fade_step_frames == '0) ? STEP_W'(1) : fade_step_frames;

  pixel_shader_4bit u_shader (
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .bright    (bright_level),
    .red_out   (shade_r),
    .green_out (shade_g),
    .blue_out  (shade_b)
  );

  always_comb begin
    next_lvl = bright_level;
    if (state == FADE_UP && bright_level < MAX_L)
      next_lvl = bright_level + 4'd1;
    else if (state == FADE_DOWN && bright_level != 4'd0)
      next_lvl = bright_level - 4'd1;
  end

  // A level step happens only on the last beat of the P-th frame since the previous step.
  assign step_now = (state != IDLE) && accept && pix_last && (frame_cnt == period - STEP_W'(1));

  assign done_set = ((state == IDLE) && fade_start && (start_tgt == bright_level))
                 || (step_now && (next_lvl == target));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      red_out   <= 4'd0;
      green_out <= 4'd0;
      blue_out  <= 4'd0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      red_out   <= shade_r;
      green_out <= shade_g;
      blue_out  <= shade_b;
      out_last  <= pix_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bright_level <= 4'd0;
      fade_busy    <= 1'b0;
      frame_cnt    <= '0;
      target       <= 4'd0;
      period       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fade_start) begin
            target    <= start_tgt;
            period    <= start_per;
            frame_cnt <= '0;
            if (start_tgt > bright_level) begin
              state     <= FADE_UP;
              fade_busy <= 1'b1;
            end else if (start_tgt < bright_level) begin
              state     <= FADE_DOWN;
              fade_busy <= 1'b1;
            end
          end else if (bright_set) begin
            bright_level <= clamp(bright_val);
          end
        end
        FADE_UP, FADE_DOWN: begin
          if (accept && pix_last) begin
            if (step_now) begin
              frame_cnt    <= '0;
              bright_level <= next_lvl;
              if (next_lvl == target) begin
                state     <= IDLE;
                fade_busy <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + STEP_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          fade_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIXEL_FADE_DONE_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) fade_done <= 1'b0;
    else     fade_done <= done_set;
  end
`else
  logic unused_done;
  assign unused_done = done_set;
`endif

endmodule

// File: tb/tb_pixel_fade_ctrl.sv
// tb/tb_pixel_fade_ctrl.sv - scoreboard bench for pixel_fade_ctrl with a fade-schedule reference model
module tb_pixel_fade_ctrl;

  localparam int MAXB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0, pix_ready, pix_last = 1'b0;
  logic [3:0] red_in = 4'd0, green_in = 4'd0, blue_in = 4'd0;
  logic       out_valid, out_ready = 1'b1, out_last;
  logic [3:0] red_out, green_out, blue_out;
  logic       fade_start = 1'b0, bright_set = 1'b0;
  logic [3:0] fade_target = 4'd0, bright_val = 4'd0;
  logic [7:0] fade_step_frames = 8'd0;
  logic [3:0] bright_level;
  logic       fade_busy;

  pixel_fade_ctrl #(.STEP_W(8), .MAX_BRIGHT(MAXB)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .pix_last(pix_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .out_last(out_last),
    .fade_start(fade_start), .fade_target(fade_target), .fade_step_frames(fade_step_frames),
    .bright_set(bright_set), .bright_val(bright_val),
    .bright_level(bright_level), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;
  logic [12:0] exp_q[$];

  // Reference model: a fade is a schedule; the level is start +/- (frames completed / P), capped at the target.
  int  lvl_static = 0;
  bit  f_active = 0;
  int  f_start = 0, f_tgt = 0, f_per = 1, f_done = 0;
  bit  m_full = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cur_level();
    int steps;
    if (!f_active) return lvl_static;
    steps = f_done / f_per;
    return (f_tgt > f_start) ? f_start + steps : f_start - steps;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic int clampb(input int v);
    return (v > MAXB) ? MAXB : v;
  endfunction

  always @(negedge clk) begin
    int lv;
    int span;
    bit acc;
    lv  = cur_level();
    acc = pix_valid && (!m_full || out_ready);
    if (chk_en) begin
      check("bright_level", int'(bright_level), lv);
      check("fade_busy", int'(fade_busy), int'(f_active));
      check("out_valid", int'(out_valid), int'(m_full));
      check("pix_ready", int'(pix_ready), int'(!m_full || out_ready));
    end
    if (rst) begin
      lvl_static = 0; f_active = 0; f_start = 0; f_tgt = 0; f_per = 1; f_done = 0;
      m_full = 0;
      exp_q.delete();
    end else begin
      if (acc)
        exp_q.push_back({pix_last, 4'(sat15(int'(red_in) + lv)), 4'(sat15(int'(green_in) + lv)),
                         4'(sat15(int'(blue_in) + lv))});
      m_full = acc ? 1'b1 : (out_ready ? 1'b0 : m_full);
      if (f_active) begin
        if (acc && pix_last) begin
          f_done++;
          span = (f_tgt > f_start) ? f_tgt - f_start : f_start - f_tgt;
          if (f_done == span * f_per) begin
            f_active   = 0;
            lvl_static = f_tgt;
          end
        end
      end else if (fade_start) begin
        f_tgt = clampb(int'(fade_target));
        f_per = (fade_step_frames == 0) ? 1 : int'(fade_step_frames);
        if (f_tgt != lvl_static) begin
          f_active = 1;
          f_start  = lvl_static;
          f_done   = 0;
        end
      end else if (bright_set) begin
        lvl_static = clampb(int'(bright_val));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pixel: got %h with no pixel expected at %0t",
                 {out_last, red_out, green_out, blue_out}, $time);
      end else begin
        check("pixel", int'({out_last, red_out, green_out, blue_out}), int'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int g, input int b, input bit last);
    bit ok;
    int n;
    pix_valid = 1'b1;
    red_in = 4'(r); green_in = 4'(g); blue_in = 4'(b);
    pix_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      ok = pix_ready;
      cyc();
      if (ok) break;
      if (++n > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got no pix_ready expected acceptance within 50 cycles");
        break;
      end
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic fade(input int tgt, input int per);
    fade_start = 1'b1;
    fade_target = 4'(tgt);
    fade_step_frames = 8'(per);
    cyc();
    fade_start = 1'b0;
  endtask

  task automatic bset(input int v);
    bright_set = 1'b1;
    bright_val = 4'(v);
    cyc();
    bright_set = 1'b0;
  endtask

  task automatic frame(input int len);
    for (int i = 0; i < len; i++)
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), i == len - 1);
  endtask

  initial begin
    repeat (2) cyc();
    chk_en = 1;
    rst = 1'b0;
    cyc();

    send(5, 6, 3, 0);
    bset(3);
    send(5, 6, 3, 0);
    send(14, 13, 15, 1);
    bset(7);
    send(0, 0, 1, 0);
    cyc();

    bset(0);
    fade(2, 2);
    for (int f = 0; f < 6; f++) frame(4);
    cyc();

    bset(5);
    fade(3, 0);
    frame(1);
    fade(15, 1);
    frame(1);
    frame(1);
    cyc();
    bset(12);
    send(1, 2, 3, 0);

    bset(0);
    fade(4, 1);
    out_ready = 1'b0;
    send(2, 3, 4, 1);
    pix_valid = 1'b1; pix_last = 1'b1; red_in = 4'd9;
    repeat (5) cyc();
    out_ready = 1'b1;
    cyc();
    pix_valid = 1'b0; pix_last = 1'b0;
    send(1, 1, 1, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 3000; i++) begin
      pix_valid        = ($urandom_range(0, 3) != 0);
      out_ready        = ($urandom_range(0, 9) < 7);
      pix_last         = ($urandom_range(0, 3) == 0);
      red_in           = 4'($urandom_range(0, 15));
      green_in         = 4'($urandom_range(0, 15));
      blue_in          = 4'($urandom_range(0, 15));
      fade_start       = ($urandom_range(0, 39) == 0);
      fade_target      = 4'($urandom_range(0, 15));
      fade_step_frames = 8'($urandom_range(0, 3));
      bright_set       = ($urandom_range(0, 29) == 0);
      bright_val       = 4'($urandom_range(0, 15));
      rst              = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0; pix_valid = 1'b0; fade_start = 1'b0; bright_set = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fade_ctrl.md
Name: pixel_fade_ctrl

Overview:
- Sequencer around one pixel_shader_4bit instance. The shader computes each output channel as min(in + bright, 15).
- Accepts a 4-bit RGB pixel stream with valid/ready and drives the shader's bright input from an internal brightness level.
- Steps that level toward a commanded target, one step every N frames, so every frame is shaded with a uniform brightness.
- Sits between the pixel source and the display/output formatter.

Parameters:
- STEP_W, 8: width of fade_step_frames and of the internal frame counter.
- MAX_BRIGHT, 15: ceiling applied to fade_target and bright_val (0..15).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  input pixel accepted when pix_valid && pix_ready.
- red_in, green_in, blue_in  in  4 each  input channels.
- pix_last  in  1  marks the final pixel of a frame.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream ready.
- red_out, green_out, blue_out  out  4 each  shaded channels.
- out_last  out  1  pix_last delayed with its pixel.
- fade_start  in  1  one-cycle fade command.
- fade_target  in  4  target level, clamped to MAX_BRIGHT.
- fade_step_frames  in  STEP_W  frames per level step; 0 is treated as 1.
- bright_set  in  1  one-cycle immediate level load.
- bright_val  in  4  value for bright_set, clamped to MAX_BRIGHT.
- bright_level  out  4  current level fed to the shader.
- fade_busy  out  1  high in FADE_UP or FADE_DOWN.

Behaviour:
- Reset: out_valid=0; red_out, green_out, blue_out = 0; out_last=0; bright_level=0; fade_busy=0; state=IDLE; frame_cnt=0; latched target and period = 0.
- Datapath: single output register. pix_ready = !out_valid || out_ready.
- Latency: a pixel accepted at cycle N appears on out_* at N+1, shaded with the bright_level value present at cycle N.
- Backpressure: while out_valid && !out_ready, all out_* hold stable.
- out_valid falls when out_ready is high and no new pixel is accepted.
- FSM states: IDLE, FADE_UP, FADE_DOWN.
- IDLE + fade_start:
  - Latch target T = min(fade_target, MAX_BRIGHT) and period P = max(fade_step_frames, 1); clear frame_cnt.
  - T > level: go to FADE_UP. T < level: go to FADE_DOWN. T == level: stay IDLE.
- IDLE + bright_set (no fade_start): bright_level <= min(bright_val, MAX_BRIGHT) next cycle.
- fade_start and bright_set in the same cycle in IDLE: fade_start wins; bright_set is dropped.
- In FADE_UP or FADE_DOWN:
  - Count only on an accepted beat with pix_last=1.
  - If frame_cnt == P-1: step bright_level by +1 (UP) or -1 (DOWN) and clear frame_cnt. Otherwise increment frame_cnt.
  - The pix_last pixel itself uses the old level; the new level applies from the next accepted pixel.
- When the stepped level equals T, return to IDLE in the same update; fade_busy falls the following cycle.
- Level never wraps: it cannot go below 0 or above MAX_BRIGHT.
- fade_start and bright_set while busy are ignored; the fade in progress continues unchanged.
- pix_last with no pixel accepted (pix_valid low or stalled) does not count.
- rst mid-fade or mid-stall: everything returns to reset values next cycle; the pixel held in the output register is discarded.

Optional Feature:
- Macro: PIXEL_FADE_DONE_PULSE_EN.
- Defined: adds output port fade_done (1 bit, reset 0). It pulses high for exactly one cycle:
  - in the cycle after the FSM returns to IDLE from FADE_UP or FADE_DOWN;
  - in the cycle after a fade_start in IDLE whose clamped target equals the current level.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Pass-through: level 0, pixel (5,6,3) with out_ready=1 -> (5,6,3) at next cycle; then bright_set with bright_val=3, then pixel (5,6,3) -> (8,9,6).
- Clamp: level 3, pixel (14,13,15) -> (15,15,15); level 7, pixel (0,0,1) -> (7,7,8).
- Fade up: level 0, fade_start with target 2 and step_frames 2, 4-pixel frames ->
  - frames 1-2 shaded at level 0, frames 3-4 at level 1, frame 5 onward at level 2;
  - fade_busy falls after the 4th pix_last.
- Fade down with over-range values: level 5, fade_start with target 3 and step_frames 0 (treated as 1) ->
  - level steps 5 -> 4 -> 3 on consecutive pix_last beats; busy drops after the 2nd.
  - A fade_start with target 15 issued mid-fade is ignored.
  - bright_set with bright_val 12 issued while MAX_BRIGHT=10 loads 10.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles with pix_valid=1 -> out_* stable and pix_ready=0; pix_last during the stall is not counted.
  - Assert rst during FADE_UP -> next cycle out_valid=0, bright_level=0, fade_busy=0.
